// File: rtl/keccak_pkg.sv
// Shared Keccak squeeze types: lane array, rate constants, FSM encoding, lane index mapping.
package keccak_pkg;

    localparam int LANE_W        = 64;
    localparam int RATE_SHAKE128 = 21;
    localparam int RATE_SHAKE256 = 17;

    typedef logic [4:0][4:0][LANE_W-1:0] state_t;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        PERM_REQ,
        PERM_WAIT
    } squeeze_state_e;

    typedef struct packed {
        logic [2:0] x;
        logic [2:0] y;
    } lane_xy_t;

    // Linear lane index i = x + 5y, as in FIPS 202.
    function automatic lane_xy_t lane_xy(input logic [4:0] idx);
        lane_xy_t r;
        r.x = 3'(idx % 5'd5);
        r.y = 3'(idx / 5'd5);
        return r;
    endfunction

endpackage

// File: rtl/keccak_lane_select.sv
// Lane mux: picks state lane idx (x+5y order); optional byte reversal under KECCAK_SQUEEZE_BYTESWAP_EN.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Only 0..24 are meaningful for idx.
module keccak_lane_select
    import keccak_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [4:0][4:0][W-1:0] state,
    input  logic [4:0]             idx,
    output logic [W-1:0]           lane
);

    lane_xy_t       xy;
    logic [W-1:0]   raw;

    always_comb begin
        xy  = lane_xy(idx);
        raw = state[xy.x][xy.y];
    end

`ifdef KECCAK_SQUEEZE_BYTESWAP_EN
    // Big-endian sinks expect byte 0 of the lane in the top byte lane.
    always_comb begin
        lane = '0;
        for (int k = 0; k < W / 8; k++) begin
            lane[k*8 +: 8] = raw[(W/8-1-k)*8 +: 8];
        end
    end
`else
    assign lane = raw;
`endif

endmodule

// File: rtl/keccak_squeeze.sv
// Sponge squeeze reader: streams rate lanes of a permuted state, re-permuting at each block edge.
// Latency: first lane the cycle after accept; block edge costs 2 cycles plus permutation latency.
// Backpressure: out_ready stalls the stream with out_lane/out_last held; in_ready only in IDLE.
// Build option: KECCAK_SQUEEZE_BYTESWAP_EN byte-reverses out_lane.
module keccak_squeeze
    import keccak_pkg::*;
#(
    parameter int W          = 64,
    parameter int RATE_LANES = RATE_SHAKE256,
    parameter int LEN_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4:0][4:0][W-1:0] in_state,
    input  logic [LEN_W-1:0]       in_lanes,
    output logic                   perm_start,
    output logic [4:0][4:0][W-1:0] perm_state,
    input  logic                   perm_done,
    input  logic [4:0][4:0][W-1:0] perm_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [W-1:0]           out_lane,
    output logic                   out_last,
    output logic                   busy
);

    if (RATE_LANES < 1 || RATE_LANES > 24) begin : g_rate_chk
        $error("keccak_squeeze: RATE_LANES must be in 1..24");
    end
    if (W % 8 != 0) begin : g_w_chk
        $error("keccak_squeeze: W must be a multiple of 8");
    end

    squeeze_state_e            st, st_d;
    logic [4:0][4:0][W-1:0]    state_q;
    logic [LEN_W-1:0]          remaining;
    logic [4:0]                rate_idx;
    logic                      last_lane;
    logic                      block_end;

    assign last_lane = (remaining == LEN_W'(1));
    assign block_end = (rate_idx == 5'(RATE_LANES - 1));

    always_comb begin
        st_d       = st;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        perm_start = 1'b0;
        case (st)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && in_lanes != '0) begin
                    st_d = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                out_last  = last_lane;
                if (out_ready) begin
                    if (last_lane) begin
                        st_d = IDLE;
                    end else if (block_end) begin
                        st_d = PERM_REQ;
                    end
                end
            end
            PERM_REQ: begin
                perm_start = 1'b1;
                st_d       = PERM_WAIT;
            end
            PERM_WAIT: begin
                if (perm_done) begin
                    st_d = EMIT;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st        <= IDLE;
            state_q   <= '0;
            remaining <= '0;
            rate_idx  <= '0;
        end else begin
            st <= st_d;
            case (st)
                IDLE: begin
                    if (in_valid) begin
                        state_q   <= in_state;
                        remaining <= in_lanes;
                        rate_idx  <= '0;
                    end
                end
                EMIT: begin
                    // remaining is non-zero here by construction; guard keeps it from wrapping.
                    if (out_ready && remaining != '0) begin
                        remaining <= remaining - LEN_W'(1);
                        rate_idx  <= rate_idx + 5'd1;
                    end
                end
                PERM_WAIT: begin
                    if (perm_done) begin
                        state_q  <= perm_result;
                        rate_idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign perm_state = state_q;
    assign busy       = (st != IDLE);

    keccak_lane_select #(
        .W (W)
    ) u_lane_select (
        .state (state_q),
        .idx   (rate_idx),
        .lane  (out_lane)
    );

endmodule

// File: tb/tb_keccak_squeeze.sv
// Directed bench for keccak_squeeze (W=64, RATE_LANES=17); expectations follow the build's byte-swap option.
module tb_keccak_squeeze;
    import keccak_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    state_t      in_state;
    logic [15:0] in_lanes;
    logic        perm_start;
    state_t      perm_state;
    logic        perm_done;
    state_t      perm_result;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_lane;
    logic        out_last;
    logic        busy;

    int nvec = 0;
    int nerr = 0;

    keccak_squeeze #(
        .W          (64),
        .RATE_LANES (17),
        .LEN_W      (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_state    (in_state),
        .in_lanes    (in_lanes),
        .perm_start  (perm_start),
        .perm_state  (perm_state),
        .perm_done   (perm_done),
        .perm_result (perm_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_lane    (out_lane),
        .out_last    (out_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] exp_lane(input logic [63:0] v);
`ifdef KECCAK_SQUEEZE_BYTESWAP_EN
        return {<<8{v}};
`else
        return v;
`endif
    endfunction

    // lane(x+5y) = base + x + 5y
    function automatic state_t make_state(input int base);
        state_t s;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                s[x][y] = 64'(base + x + 5 * y);
        return s;
    endfunction

    task automatic accept_job(input int n);
        in_lanes = 16'(n);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; perm_done = 1'b0; out_ready = 1'b0;
        in_lanes = '0; in_state = '0; perm_result = '0;
        for (int c = 0; c < 3; c++) step();
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        nvec++; if (perm_start !== 1'b0) begin nerr++; $display("FAIL reset_perm_start got %b want 0", perm_start); end
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
        rst_n = 1'b1;
        step();
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_short();
        in_state  = make_state(0);
        out_ready = 1'b1;
        accept_job(4);
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (out_valid !== 1'b1 || out_lane !== exp_lane(64'(i)) || out_last !== (i == 3) || perm_start !== 1'b0) begin
                nerr++;
                $display("FAIL short_beat%0d got v=%b lane=%h last=%b ps=%b want v=1 lane=%h last=%b ps=0",
                         i, out_valid, out_lane, out_last, perm_start, exp_lane(64'(i)), (i == 3));
            end
            step();
        end
        nvec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            nerr++; $display("FAIL short_after got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_block_crossing();
        int idx = 0, starts = 0, done_at = -1, cyc = 0;
        logic [63:0] want;
        in_state    = make_state(0);
        perm_result = make_state(100);
        out_ready   = 1'b1;
        accept_job(20);
        while (idx < 20 && cyc < 200) begin
            if (perm_start === 1'b1) begin
                starts++;
                done_at = cyc + 3;
                nvec++;
                if (perm_state !== in_state) begin
                    nerr++; $display("FAIL cross_perm_state got %h want %h", perm_state[0][0], in_state[0][0]);
                end
            end
            if (out_valid === 1'b1) begin
                want = exp_lane(64'(idx < 17 ? idx : 100 + idx - 17));
                nvec++;
                if (out_lane !== want || out_last !== (idx == 19)) begin
                    nerr++; $display("FAIL cross_beat%0d got lane=%h last=%b want lane=%h last=%b",
                                     idx, out_lane, out_last, want, (idx == 19));
                end
                idx++;
            end
            perm_done = (cyc == done_at);
            step();
            cyc++;
        end
        perm_done = 1'b0;
        nvec++; if (idx != 20) begin nerr++; $display("FAIL cross_beats got %0d want 20", idx); end
        nvec++; if (starts != 1) begin nerr++; $display("FAIL cross_perm_starts got %0d want 1", starts); end
        nvec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            nerr++; $display("FAIL cross_after got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [5:0]  pat = 6'b101001;
        logic        prev_stall = 1'b0;
        logic [63:0] prev_lane = '0;
        int idx = 0, cyc = 0;
        in_state  = make_state(0);
        out_ready = 1'b0;
        accept_job(6);
        while (idx < 6 && cyc < 100) begin
            if (prev_stall) begin
                nvec++;
                if (out_valid !== 1'b1 || out_lane !== prev_lane) begin
                    nerr++; $display("FAIL bp_stall_hold got v=%b lane=%h want v=1 lane=%h", out_valid, out_lane, prev_lane);
                end
            end
            out_ready = pat[cyc % 6];
            if (out_valid === 1'b1 && out_ready) begin
                nvec++;
                if (out_lane !== exp_lane(64'(idx)) || out_last !== (idx == 5)) begin
                    nerr++; $display("FAIL bp_beat%0d got lane=%h last=%b want lane=%h last=%b",
                                     idx, out_lane, out_last, exp_lane(64'(idx)), (idx == 5));
                end
                idx++;
            end
            prev_stall = (out_valid === 1'b1) && !out_ready;
            prev_lane  = out_lane;
            step();
            cyc++;
        end
        out_ready = 1'b1;
        nvec++; if (idx != 6) begin nerr++; $display("FAIL bp_beats got %0d want 6", idx); end
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL bp_after got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_zero_len();
        int seen = 0;
        in_state  = make_state(0);
        out_ready = 1'b1;
        accept_job(0);
        for (int c = 0; c < 8; c++) begin
            if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
            step();
        end
        nvec++; if (seen != 0) begin nerr++; $display("FAIL zero_len got %0d active cycles want 0", seen); end
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL zero_len_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_reset_abort();
        int cyc = 0;
        in_state    = make_state(0);
        perm_result = make_state(100);
        out_ready   = 1'b1;
        accept_job(20);
        while (perm_start !== 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        nvec++; if (perm_start !== 1'b1) begin nerr++; $display("FAIL abort_perm_start got %b want 1", perm_start); end
        step();
        nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL abort_wait_busy got %b want 1", busy); end
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        perm_done = 1'b1;
        step();
        perm_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            nvec++;
            if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
                nerr++; $display("FAIL abort_idle%0d got busy=%b v=%b in_ready=%b want 0/0/1", c, busy, out_valid, in_ready);
            end
            step();
        end
    endtask

    task automatic test_byteswap();
        logic [63:0] want;
`ifdef KECCAK_SQUEEZE_BYTESWAP_EN
        want = 64'hEFCDAB8967452301;
`else
        want = 64'h0123456789ABCDEF;
`endif
        in_state       = make_state(0);
        in_state[0][0] = 64'h0123456789ABCDEF;
        out_ready      = 1'b1;
        accept_job(1);
        nvec++;
        if (out_valid !== 1'b1 || out_lane !== want || out_last !== 1'b1) begin
            nerr++; $display("FAIL byteswap got v=%b lane=%h last=%b want v=1 lane=%h last=1", out_valid, out_lane, out_last, want);
        end
        step();
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL byteswap_after got out_valid=%b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_short();
        test_block_crossing();
        test_backpressure();
        test_zero_len();
        test_reset_abort();
        test_byteswap();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
